// File: rtl/data_mem_responder_if.sv
// Load/store port between the CPU MEM stage and the data memory responder.
// The CPU drives the request side and consumes responses; the responder does the reverse.
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Word-wide data memory with a programmable number of wait states, answering one
// load/store at a time over valid/ready request and response handshakes.
module data_mem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    data_mem_responder_if.slave   bus
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        WAIT   = 2'b01,
        RESP   = 2'b10,
        UNUSED = 2'b11
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH];

    logic          acc_en;
    logic          acc_write;
    logic          acc_err;
    logic          mem_we;
    logic [31:0]   acc_addr;
    logic [31:0]   acc_wdata;
    logic [AW-1:0] acc_idx;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        write_d   = write_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        acc_en    = 1'b0;
        acc_write = write_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    write_d   = bus.req_write;
                    addr_d    = bus.req_addr;
                    wdata_d   = bus.req_wdata;
                    // With no wait states the access uses the request as it arrives.
                    acc_write = bus.req_write;
                    acc_addr  = bus.req_addr;
                    acc_wdata = bus.req_wdata;
                    if (LATENCY == 0) begin
                        state_d = RESP;
                        acc_en  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    acc_en  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_d = IDLE;
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
                rdata_d = 32'd0;
                err_d   = 1'b0;
            end
        endcase

        acc_err = (acc_addr[1:0] != 2'b00) || (acc_addr[31:2] >= 30'(DEPTH));
        acc_idx = acc_addr[AW+1:2];

        if (acc_en) begin
            err_d   = acc_err;
            rdata_d = (acc_err || acc_write) ? 32'd0 : mem[acc_idx];
        end

        // Gating with reset keeps a store from landing while reset is held.
        mem_we = acc_en && acc_write && !acc_err && reset;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a LATENCY=2 instance for most traffic and a
// LATENCY=0 instance for back-to-back spacing.
module tb_data_mem_responder;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    data_mem_responder_if bus2 ();
    data_mem_responder_if bus0 ();

    data_mem_responder #(.DEPTH(256), .LATENCY(2)) u_dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.slave)
    );

    data_mem_responder #(.DEPTH(256), .LATENCY(0)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Full transaction on the LATENCY=2 port; checks handshake timing on the way.
    task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er);
        int n;
        n = 0;
        bus2.req_valid = 1'b1;
        bus2.req_write = w;
        bus2.req_addr  = a;
        bus2.req_wdata = d;
        tick;
        bus2.req_valid = 1'b0;
        while (bus2.resp_valid !== 1'b1 && n < 20) begin
            tick;
            n++;
        end
        chk("resp_timeout", {31'd0, bus2.resp_valid}, 32'd1);
        chk("resp_latency", n, 32'd2);
        rd = bus2.resp_rdata;
        er = bus2.resp_err;
        bus2.resp_ready = 1'b1;
        tick;
        bus2.resp_ready = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b0;
        bus2.req_valid = 1'b0; bus2.req_write = 1'b0; bus2.req_addr = '0; bus2.req_wdata = '0;
        bus2.resp_ready = 1'b0;
        bus0.req_valid = 1'b0; bus0.req_write = 1'b0; bus0.req_addr = '0; bus0.req_wdata = '0;
        bus0.resp_ready = 1'b0;

        // Reset state
        tick; tick;
        chk("rst_req_ready",  {31'd0, bus2.req_ready},  32'd1);
        chk("rst_resp_valid", {31'd0, bus2.resp_valid}, 32'd0);
        chk("rst_resp_rdata", bus2.resp_rdata,          32'd0);
        chk("rst_resp_err",   {31'd0, bus2.resp_err},   32'd0);
        reset = 1'b1;
        tick;

        // Store 0xDEADBEEF to 0x10 with explicit cycle-by-cycle timing
        bus2.req_valid = 1'b1; bus2.req_write = 1'b1;
        bus2.req_addr = 32'h10; bus2.req_wdata = 32'hDEADBEEF;
        tick;
        bus2.req_valid = 1'b0;
        chk("st_ready_c1", {31'd0, bus2.req_ready},  32'd0);
        chk("st_valid_c1", {31'd0, bus2.resp_valid}, 32'd0);
        tick;
        chk("st_ready_c2", {31'd0, bus2.req_ready},  32'd0);
        chk("st_valid_c2", {31'd0, bus2.resp_valid}, 32'd0);
        tick;
        chk("st_ready_c3", {31'd0, bus2.req_ready},  32'd0);
        chk("st_valid_c3", {31'd0, bus2.resp_valid}, 32'd1);
        chk("st_err",      {31'd0, bus2.resp_err},   32'd0);
        chk("st_rdata",    bus2.resp_rdata,          32'd0);
        bus2.resp_ready = 1'b1;
        tick;
        bus2.resp_ready = 1'b0;
        chk("st_done_valid", {31'd0, bus2.resp_valid}, 32'd0);
        chk("st_done_ready", {31'd0, bus2.req_ready},  32'd1);

        // Load 0x10 with response held off for 4 cycles
        bus2.req_valid = 1'b1; bus2.req_write = 1'b0; bus2.req_addr = 32'h10;
        tick;
        bus2.req_valid = 1'b0;
        tick; tick;
        for (int i = 0; i < 4; i++) begin
            chk("ld_hold_valid", {31'd0, bus2.resp_valid}, 32'd1);
            chk("ld_hold_rdata", bus2.resp_rdata,          32'hDEADBEEF);
            tick;
        end
        bus2.resp_ready = 1'b1;
        tick;
        bus2.resp_ready = 1'b0;
        chk("ld_clr_valid", {31'd0, bus2.resp_valid}, 32'd0);
        chk("ld_clr_rdata", bus2.resp_rdata,          32'd0);

        // Misaligned store, then confirm the word is untouched
        xact(1'b1, 32'h12, 32'h11111111, rd, er);
        chk("mis_err",   {31'd0, er}, 32'd1);
        chk("mis_rdata", rd,          32'd0);
        xact(1'b0, 32'h10, 32'h0, rd, er);
        chk("mis_after_rdata", rd,          32'hDEADBEEF);
        chk("mis_after_err",   {31'd0, er}, 32'd0);

        // Out-of-range accesses; word 0 would alias 0x400 if the index were truncated
        xact(1'b1, 32'h0, 32'h5555AAAA, rd, er);
        xact(1'b0, 32'h400, 32'h0, rd, er);
        chk("oor_ld_err",   {31'd0, er}, 32'd1);
        chk("oor_ld_rdata", rd,          32'd0);
        xact(1'b1, 32'h400, 32'hAAAAAAAA, rd, er);
        chk("oor_st_err", {31'd0, er}, 32'd1);
        xact(1'b0, 32'h0, 32'h0, rd, er);
        chk("oor_word0", rd, 32'h5555AAAA);
        xact(1'b0, 32'h10, 32'h0, rd, er);
        chk("oor_word4", rd, 32'hDEADBEEF);

        // Highest legal word
        xact(1'b1, 32'h3FC, 32'hCAFEF00D, rd, er);
        chk("top_st_err", {31'd0, er}, 32'd0);
        xact(1'b0, 32'h3FC, 32'h0, rd, er);
        chk("top_ld_rdata", rd,          32'hCAFEF00D);
        chk("top_ld_err",   {31'd0, er}, 32'd0);

        // Read-after-write; resp_ready raised early has no effect before resp_valid
        bus2.resp_ready = 1'b1;
        xact(1'b1, 32'h30, 32'hA5A5_5A5A, rd, er);
        xact(1'b0, 32'h30, 32'h0, rd, er);
        chk("raw_rdata", rd, 32'hA5A55A5A);

        // LATENCY=0 instance: one-cycle response and 2-cycle request spacing
        bus0.req_valid = 1'b1; bus0.req_write = 1'b1;
        bus0.req_addr = 32'h8; bus0.req_wdata = 32'h13579BDF;
        tick;
        bus0.req_valid = 1'b0;
        chk("l0_st_valid", {31'd0, bus0.resp_valid}, 32'd1);
        bus0.resp_ready = 1'b1;
        tick;
        bus0.resp_ready = 1'b0;
        bus0.req_valid = 1'b1; bus0.req_write = 1'b0; bus0.req_addr = 32'h8;
        tick;
        chk("l0_ld_valid", {31'd0, bus0.resp_valid}, 32'd1);
        chk("l0_ld_ready", {31'd0, bus0.req_ready},  32'd0);
        chk("l0_ld_rdata", bus0.resp_rdata,          32'h13579BDF);
        bus0.resp_ready = 1'b1;
        tick;
        chk("l0_gap_valid", {31'd0, bus0.resp_valid}, 32'd0);
        chk("l0_gap_ready", {31'd0, bus0.req_ready},  32'd1);
        tick;
        chk("l0_2nd_valid", {31'd0, bus0.resp_valid}, 32'd1);
        chk("l0_2nd_rdata", bus0.resp_rdata,          32'h13579BDF);
        bus0.req_valid = 1'b0;
        tick;
        bus0.resp_ready = 1'b0;

        // Reset during WAIT aborts the store
        bus2.resp_ready = 1'b0;
        xact(1'b1, 32'h20, 32'h0BADF00D, rd, er);
        bus2.req_valid = 1'b1; bus2.req_write = 1'b1;
        bus2.req_addr = 32'h20; bus2.req_wdata = 32'h12345678;
        tick;
        bus2.req_valid = 1'b0;
        chk("abort_in_wait", {31'd0, bus2.req_ready}, 32'd0);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_req_ready",  {31'd0, bus2.req_ready},  32'd1);
        chk("abort_resp_valid", {31'd0, bus2.resp_valid}, 32'd0);
        chk("abort_resp_rdata", bus2.resp_rdata,          32'd0);
        chk("abort_resp_err",   {31'd0, bus2.resp_err},   32'd0);
        tick; tick;
        reset = 1'b1;
        tick;
        xact(1'b0, 32'h20, 32'h0, rd, er);
        chk("abort_prior_data", rd, 32'h0BADF00D);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
